// File: rtl/stream_mux_arb_pkg.sv
// Shared constants for the stream_mux_arb block: mode encodings and the
// width/saturation value of the optional per-channel transfer counters.
package stream_mux_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational grant logic for stream_mux_arb.
// Fixed mode grants select when that channel requests; selects beyond the
// instantiated channels see a zero request and never grant.
// Round-robin mode grants the first requester after the previous winner,
// wrapping around the channel range.
module stream_mux_arb_rr_arbiter
  import stream_mux_arb_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [SEL_W-1:0]    i_last,
  input  logic                i_mode,
  input  logic [SEL_W-1:0]    i_select,
  output logic [SEL_W-1:0]    o_grant,
  output logic                o_grant_valid
);

  logic [(2**SEL_W)-1:0] w_req_ext;
  logic [SEL_W-1:0]      w_cand_hi;
  logic [SEL_W-1:0]      w_cand_lo;
  logic                  w_hi_valid;
  logic                  w_lo_valid;

  // Zero-extend requests to the full select range so any select value indexes safely.
  always_comb begin
    w_req_ext                 = '0;
    w_req_ext[CHANNELS-1:0]   = i_req;
  end

  // Lowest requester above the last winner, and lowest at-or-below it (wrap case).
  always_comb begin
    w_cand_hi  = '0;
    w_cand_lo  = '0;
    w_hi_valid = 1'b0;
    w_lo_valid = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        if (k > int'(i_last)) begin
          w_cand_hi  = SEL_W'(k);
          w_hi_valid = 1'b1;
        end else begin
          w_cand_lo  = SEL_W'(k);
          w_lo_valid = 1'b1;
        end
      end
    end
  end

  // Final grant selection per mode.
  always_comb begin
    o_grant       = '0;
    o_grant_valid = 1'b0;
    if (i_mode == MODE_RR) begin
      o_grant_valid = w_hi_valid | w_lo_valid;
      o_grant       = w_hi_valid ? w_cand_hi : w_cand_lo;
    end else begin
      o_grant_valid = w_req_ext[i_select];
      o_grant       = i_select;
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-to-1 valid/ready stream selector with one registered output stage.
// Fixed-select or round-robin arbitration; the round-robin pointer only
// advances on round-robin transfers and survives mode changes.
// Optional per-channel saturating transfer counters: STREAM_MUX_COUNT_EN.
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mode_i,
  input  logic [SEL_W-1:0]          select_i,
  input  logic [CHANNELS-1:0]       in_valid_i,
  input  logic [CHANNELS*WIDTH-1:0] in_data_i,
  output logic [CHANNELS-1:0]       in_ready_o,
  output logic                      out_valid_o,
  output logic [WIDTH-1:0]          out_data_o,
  output logic [SEL_W-1:0]          out_chan_o,
  input  logic                      out_ready_i
`ifdef STREAM_MUX_COUNT_EN
  ,
  output logic [CHANNELS*CNT_W-1:0] xfer_cnt_o
`endif
);

  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [SEL_W-1:0]  r_chan;
  logic [SEL_W-1:0]  r_last;

  logic              w_load;
  logic              w_xfer;
  logic [SEL_W-1:0]  w_grant;
  logic              w_grant_valid;
  logic [WIDTH-1:0]  w_grant_data;

  stream_mux_arb_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .i_req         (in_valid_i),
    .i_last        (r_last),
    .i_mode        (mode_i),
    .i_select      (select_i),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid)
  );

  // Output register may take a new word when empty or being drained this cycle.
  assign w_load = ~r_valid | out_ready_i;
  // Reset suppresses handshakes so no upstream word is lost to a discarded load.
  assign w_xfer = w_grant_valid & w_load & ~rst_i;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign in_ready_o[gi] = w_xfer & (w_grant == SEL_W'(gi));
    end
  endgenerate

  // Data of the granted channel.
  always_comb begin
    w_grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_grant == SEL_W'(k)) begin
        w_grant_data = in_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_last  <= SEL_W'(CHANNELS - 1);
    end else if (w_load) begin
      if (w_grant_valid) begin
        r_valid <= 1'b1;
        r_data  <= w_grant_data;
        r_chan  <= w_grant;
        if (mode_i == MODE_RR) begin
          r_last <= w_grant;
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_chan_o  = r_chan;

`ifdef STREAM_MUX_COUNT_EN
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      // Saturating count of accepted words on this channel.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_cnt <= '0;
        end else if (in_ready_o[gi] && in_valid_i[gi] && (r_cnt != CNT_SAT)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign xfer_cnt_o[gi*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate
`endif

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised N-to-1 datapath selector with valid/ready handshakes and one registered output stage.
- Generalises the 2-to-1 select mux to CHANNELS inputs.
- Two modes: explicit select, or round-robin arbitration.
- Used in the pipelined CPU datapath, e.g. for merging writeback and forwarding sources or memory request streams.

Parameters:
- WIDTH, 32, data width per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, select/channel-index width; must satisfy 2^SEL_W >= CHANNELS.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- mode_i  input  1  0 = fixed select, 1 = round-robin.
- select_i  input  SEL_W  channel index used when mode_i=0.
- in_valid_i  input  CHANNELS  per-channel valid.
- in_data_i  input  CHANNELS*WIDTH  packed data; channel k is bits [k*WIDTH +: WIDTH].
- in_ready_o  output  CHANNELS  per-channel ready; one-hot or zero.
- out_valid_o  output  1  output register holds a valid word.
- out_data_o  output  WIDTH  registered data.
- out_chan_o  output  SEL_W  source channel of out_data_o.
- out_ready_i  input  1  downstream accepts the word.

Behaviour:
- Reset (rst_i=1 at an edge):
  - out_valid_o=0, out_data_o=0, out_chan_o=0.
  - Round-robin pointer last_q=CHANNELS-1, so channel 0 has first priority.
  - Reset overrides any transfer in the same cycle; a held word is discarded.
- Load condition: load = ~out_valid_o | out_ready_i. This allows full throughput of one word per cycle, and a drain and refill in the same cycle.
- Grant g is combinational:
  - mode_i=0: grant is select_i when select_i<CHANNELS and in_valid_i[select_i]=1. Otherwise no grant; select_i>=CHANNELS never grants.
  - mode_i=1: grant is the first k with in_valid_i[k]=1, searching last_q+1, last_q+2, … and wrapping modulo CHANNELS. No grant if all in_valid_i=0.
- in_ready_o[g] = load when a grant exists; every other bit is 0. in_ready_o never depends combinationally on in_valid_i of non-granted channels in mode 0.
- Transfer on channel g = in_valid_i[g] & in_ready_o[g]. At the edge:
  - out_data_o <= channel g data.
  - out_chan_o <= g.
  - out_valid_o <= 1.
  - In mode 1 only, last_q <= g.
- load with no grant: out_valid_o <= 0. out_data_o and out_chan_o hold their values.
- ~load (stalled): all outputs hold and in_ready_o=0.
- Latency: input transfer to out_valid_o is 1 cycle.
- last_q is not updated in mode 0 and keeps its value across mode changes.
- A mode_i or select_i change affects only the next grant decision; it never alters a word already held.
- Upstream must hold in_valid_i and data until its ready is seen; a valid may drop only after a transfer.

Optional Feature:
- Macro: STREAM_MUX_COUNT_EN.
- With the macro defined:
  - Adds output xfer_cnt_o (CHANNELS*16 bits), one 16-bit per-channel transfer counter.
  - A channel's counter increments on each transfer of that channel.
  - Counters saturate at 16'hFFFF and clear on rst_i.
- Without the macro: the port and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared header stream_mux_defs.vh, holding:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - Counter width 16.
  - Saturation value 16'hFFFF.
- One natural sub-module, rr_arbiter: combinational.
  - Inputs: request vector, last_q, mode, select.
  - Outputs: grant index and grant_valid.
  - Instantiated once.
- The output register and last_q stay in stream_mux_arb.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles with all in_valid_i=1 → out_valid_o=0, in_ready_o=0 during reset. Then mode 1 grants channel 0 first and out_chan_o=0 one cycle later.
- Fixed select: mode_i=0, select_i=2, in_valid_i=4'b1111, ch2 data=32'hA5A5_0002, out_ready_i=1 → every cycle in_ready_o=4'b0100, out_data_o=32'hA5A5_0002, out_chan_o=2. With select_i=5 on an 8-channel build where only 4 are instantiated → no grant, out_valid_o falls to 0.
- Round-robin fairness: mode_i=1, in_valid_i=4'b1011 held, out_ready_i=1 → out_chan_o sequence 0,1,3,0,1,3; channel 2 is never granted.
- Backpressure: out_valid_o=1 and out_ready_i=0 for 3 cycles → in_ready_o=0 and out_data_o stable. Then out_ready_i=1 → the next word loads in the same cycle, with no bubble.
- Reset mid-operation: out_valid_o=1 holding ch3 with last_q=3, assert rst_i → next cycle out_valid_o=0 and last_q=3 (CHANNELS-1). The next round-robin grant with all valid is channel 0.
- STREAM_MUX_COUNT_EN: 70000 back-to-back transfers on channel 1 → xfer_cnt_o channel 1 = 16'hFFFF and other channels 0. Without the macro, the build has no xfer_cnt_o port.
